// File: rtl/pipe_defs_pkg.sv
// rtl/pipe_defs_pkg.sv - opcode/funct/aluc constants and ID/EX bubble value for the pipelined core
// Contents:
//   OP_*        primary opcodes decoded in ID
//   F_*         R-type funct codes
//   aluc_e      ALU op codes, shared with the ALU and the single-cycle control
//   idex_t      ID/EX pipeline register payload
//   IDEX_BUBBLE all-zero payload: ADD with no register/memory writes
package pipe_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_AND = 4'b0001,
    ALU_XOR = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_LUI = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_SRA = 4'b1111
  } aluc_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic [31:0] sd;
    logic [4:0]  rn;
    logic        wreg;
    logic        m2reg;
    logic        wmem;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/pipe_fwd_mux.sv
// rtl/pipe_fwd_mux.sv - one-operand forwarding priority mux (EX, then MEM, then register file)
// Ports:
//   r         source register number being read in ID
//   rf_val    register-file read value for r
//   ex_*      destination/enables/result of the instruction in EX
//   mem_*     destination/enables/results of the instruction in MEM
//   fwd_val   freshest value of r
module pipe_fwd_mux (
  input  logic [4:0]  r,
  input  logic [31:0] rf_val,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rn,
  input  logic [31:0] ex_alu,
  input  logic        mem_wreg,
  input  logic        mem_m2reg,
  input  logic [4:0]  mem_rn,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_mo,
  output logic [31:0] fwd_val
);

  // A load in EX has no data yet; that case is covered by the load-use stall.
  logic hit_ex;
  logic hit_mem;

  assign hit_ex  = ex_wreg & ~ex_m2reg & (ex_rn == r) & (r != 5'd0);
  assign hit_mem = mem_wreg & (mem_rn == r) & (r != 5'd0);

  always_comb begin
    fwd_val = rf_val;
    if (hit_ex)
      fwd_val = ex_alu;
    else if (hit_mem)
      fwd_val = mem_m2reg ? mem_mo : mem_alu;
  end

endmodule

// File: rtl/pipe_idex_ctrl.sv
// rtl/pipe_idex_ctrl.sv - ID-stage decode, forwarding, load-use stall and ID/EX register
// Ports:
//   clock, reset             rising-edge clock, synchronous active-high reset
//   id_inst, id_qa, id_qb    instruction in ID and its register-file reads (rs, rt)
//   flush                    kill the ID instruction (captures a bubble)
//   ex_alu                   ALU result of the instruction in EX
//   mem_rn/wreg/m2reg/alu/mo MEM-stage destination, enables and results
//   stall                    combinational: hold PC and IF/ID this cycle
//   ex_a/b/aluc/sd/rn        registered ALU operands, op, store data, destination
//   ex_wreg/m2reg/wmem       registered write/load/store enables
module pipe_idex_ctrl
  import pipe_defs_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_qa,
  input  logic [31:0] id_qb,
  input  logic        flush,
  input  logic [31:0] ex_alu,
  input  logic [4:0]  mem_rn,
  input  logic        mem_wreg,
  input  logic        mem_m2reg,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_mo,
  output logic        stall,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [3:0]  ex_aluc,
  output logic [31:0] ex_sd,
  output logic [4:0]  ex_rn,
  output logic        ex_wreg,
  output logic        ex_m2reg,
  output logic        ex_wmem
);

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [5:0]  funct;
  logic [15:0] imm;

  assign op    = id_inst[31:26];
  assign rs    = id_inst[25:21];
  assign rt    = id_inst[20:16];
  assign rd    = id_inst[15:11];
  assign sa    = id_inst[10:6];
  assign funct = id_inst[5:0];
  assign imm   = id_inst[15:0];

  idex_t       q;
  idex_t       d;
  logic [31:0] fa;
  logic [31:0] fb;
  logic        valid;
  logic        uses_rs;
  logic        uses_rt;
  logic        hazard;

  pipe_fwd_mux u_fwd_rs (
    .r         (rs),
    .rf_val    (id_qa),
    .ex_wreg   (q.wreg),
    .ex_m2reg  (q.m2reg),
    .ex_rn     (q.rn),
    .ex_alu    (ex_alu),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .mem_alu   (mem_alu),
    .mem_mo    (mem_mo),
    .fwd_val   (fa)
  );

  pipe_fwd_mux u_fwd_rt (
    .r         (rt),
    .rf_val    (id_qb),
    .ex_wreg   (q.wreg),
    .ex_m2reg  (q.m2reg),
    .ex_rn     (q.rn),
    .ex_alu    (ex_alu),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .mem_alu   (mem_alu),
    .mem_mo    (mem_mo),
    .fwd_val   (fb)
  );

  always_comb begin
    d       = IDEX_BUBBLE;
    valid   = 1'b1;
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    d.a     = fa;
    d.wreg  = 1'b1;
    d.rn    = rt;
    unique case (op)
      OP_RTYPE: begin
        uses_rt = 1'b1;
        d.b     = fb;
        d.rn    = rd;
        unique case (funct)
          F_ADD: d.aluc = ALU_ADD;
          F_SUB: d.aluc = ALU_SUB;
          F_AND: d.aluc = ALU_AND;
          F_OR:  d.aluc = ALU_OR;
          F_XOR: d.aluc = ALU_XOR;
          F_SLL, F_SRL, F_SRA: begin
            // Shifts take the shift amount from the instruction, not rs.
            uses_rs = 1'b0;
            d.a     = {27'b0, sa};
            d.aluc  = (funct == F_SLL) ? ALU_SLL :
                      (funct == F_SRL) ? ALU_SRL : ALU_SRA;
          end
          default: valid = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        d.aluc  = ALU_ADD;
        d.b     = {{16{imm[15]}}, imm};
        d.m2reg = (op == OP_LW);
        d.wmem  = (op == OP_SW);
        d.wreg  = (op != OP_SW);
        uses_rt = (op == OP_SW);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        d.b    = {16'b0, imm};
        d.aluc = (op == OP_ANDI) ? ALU_AND :
                 (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: begin
        uses_rs = 1'b0;
        d.b     = {16'b0, imm};
        d.aluc  = ALU_LUI;
      end
      default: valid = 1'b0;
    endcase

    d.sd = fb;
    if (d.rn == 5'd0)
      d.wreg = 1'b0;

    // Unsupported encodings decode to a full bubble and never cause a stall.
    if (!valid) begin
      d       = IDEX_BUBBLE;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
    end
  end

  // A load in EX cannot forward; the dependent instruction waits one cycle
  // and then picks the load data up from MEM.
  assign hazard = q.wreg & q.m2reg &
                  ((uses_rs & (q.rn == rs)) | (uses_rt & (q.rn == rt)));
  assign stall  = hazard & ~flush;

  always_ff @(posedge clock) begin
    if (reset)
      q <= IDEX_BUBBLE;
    else if (flush | hazard)
      q <= IDEX_BUBBLE;
    else
      q <= d;
  end

  assign ex_a     = q.a;
  assign ex_b     = q.b;
  assign ex_aluc  = q.aluc;
  assign ex_sd    = q.sd;
  assign ex_rn    = q.rn;
  assign ex_wreg  = q.wreg;
  assign ex_m2reg = q.m2reg;
  assign ex_wmem  = q.wmem;

endmodule
